// File: rtl/conv_pkg.sv
// Shared definitions for the convolution output buffer: input FSM states and
// the per-matrix output element count.
package conv_pkg;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_COLLECT = 1'b1
  } in_state_e;

  // Number of valid convolution positions for a KxK kernel over an RxC matrix.
  function automatic int unsigned num_outputs(input int unsigned rows,
                                              input int unsigned cols,
                                              input int unsigned k);
    return (rows - k + 1) * (cols - k + 1);
  endfunction

endpackage

// File: rtl/out_fifo.sv
// Synchronous FIFO with wrap-bit pointers and a combinational head read,
// so a word written on one edge is visible at the head right after it.
module out_fifo #(
  parameter int W     = 49,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] wdata,
  output logic         full,
  input  logic         pop,
  output logic         empty,
  output logic [W-1:0] rdata
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]  rd_ptr_q, rd_ptr_d;
  logic [W-1:0] mem_q [DEPTH];
  logic         do_push, do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage is never reset; pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/output_mems.sv
// Buffers convolution results into an AXI-Stream, tagging the final element
// of each output matrix with TLAST and pulsing matrix_done once it leaves.
module output_mems
  import conv_pkg::*;
#(
  parameter int OUTW  = 48,
  parameter int R     = 9,
  parameter int C     = 8,
  parameter int MAXK  = 4,
  parameter int DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [$clog2(MAXK+1)-1:0]     K,
  input  logic signed [OUTW-1:0]        in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic signed [OUTW-1:0]        AXIS_TDATA,
  output logic                          AXIS_TVALID,
  input  logic                          AXIS_TREADY,
  output logic                          AXIS_TLAST,
  output logic                          matrix_done
);

  localparam int K_BITS = $clog2(MAXK+1);
  localparam int CNT_W  = $clog2(R*C+1);

  in_state_e          state_q, state_d;
  logic [K_BITS-1:0]  k_reg_q, k_reg_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               matrix_done_q, matrix_done_d;

  logic               push, pop, tag_last;
  logic               fifo_full, fifo_empty;
  logic [OUTW:0]      fifo_rdata;
  logic [K_BITS-1:0]  k_sel;
  int unsigned        n_total;
  int unsigned        cnt_inc;

  assign in_ready    = ~fifo_full;
  assign AXIS_TVALID = ~fifo_empty;
  assign AXIS_TDATA  = $signed(fifo_rdata[OUTW-1:0]);
  assign AXIS_TLAST  = ~fifo_empty & fifo_rdata[OUTW];
  assign matrix_done = matrix_done_q;
  assign push        = in_valid & in_ready;
  assign pop         = AXIS_TVALID & AXIS_TREADY;

  // K is only sampled on the first push of a matrix; afterwards k_reg rules.
  always_comb begin
    state_d       = state_q;
    k_reg_d       = k_reg_q;
    cnt_d         = cnt_q;
    tag_last      = 1'b0;
    k_sel         = (state_q == ST_IDLE) ? K : k_reg_q;
    n_total       = num_outputs(R, C, 32'(k_sel));
    cnt_inc       = 32'(cnt_q) + 32'd1;
    matrix_done_d = pop & AXIS_TLAST;
    if (push) begin
      if (state_q == ST_IDLE) k_reg_d = K;
      if (cnt_inc == n_total) begin
        tag_last = 1'b1;
        cnt_d    = '0;
        state_d  = ST_IDLE;
      end else begin
        cnt_d    = cnt_q + 1'b1;
        state_d  = ST_COLLECT;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      k_reg_q       <= '0;
      cnt_q         <= '0;
      matrix_done_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      k_reg_q       <= k_reg_d;
      cnt_q         <= cnt_d;
      matrix_done_q <= matrix_done_d;
    end
  end

  out_fifo #(
    .W     (OUTW + 1),
    .DEPTH (DEPTH)
  ) u_out_fifo (
    .clk   (clk),
    .rst_n (reset),
    .push  (push),
    .wdata ({tag_last, in_data}),
    .full  (fifo_full),
    .pop   (pop),
    .empty (fifo_empty),
    .rdata (fifo_rdata)
  );

endmodule

// File: tb/tb_output_mems.sv
// Directed bench for output_mems: scoreboard of pushed words with expected
// TLAST tags, per-cycle matrix_done and hold-stability checks.
module tb_output_mems;

  localparam int OUTW  = 48;
  localparam int R     = 9;
  localparam int C     = 8;
  localparam int MAXK  = 4;
  localparam int DEPTH = 8;
  localparam int KB    = $clog2(MAXK+1);

  logic                   clk = 1'b0;
  logic                   reset;
  logic [KB-1:0]          K;
  logic signed [OUTW-1:0] in_data;
  logic                   in_valid;
  logic                   in_ready;
  logic signed [OUTW-1:0] AXIS_TDATA;
  logic                   AXIS_TVALID;
  logic                   AXIS_TREADY;
  logic                   AXIS_TLAST;
  logic                   matrix_done;

  always #5 clk = ~clk;

  output_mems #(
    .OUTW(OUTW), .R(R), .C(C), .MAXK(MAXK), .DEPTH(DEPTH)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .K           (K),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .AXIS_TDATA  (AXIS_TDATA),
    .AXIS_TVALID (AXIS_TVALID),
    .AXIS_TREADY (AXIS_TREADY),
    .AXIS_TLAST  (AXIS_TLAST),
    .matrix_done (matrix_done)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  logic [OUTW:0]   exp_q[$];
  logic [OUTW:0]   mon_e;
  logic [OUTW:0]   held;
  logic [OUTW-1:0] last_tlast_data = '0;
  int              tlast_cnt = 0;
  bit              prev_pop_last = 1'b0;
  bit              hold_pend = 1'b0;
  bit              toggle_mode = 1'b0;

  always @(posedge clk) begin
    #1;
    if (toggle_mode) AXIS_TREADY = ~AXIS_TREADY;
  end

  always @(negedge clk) begin
    if (!reset) begin
      prev_pop_last = 1'b0;
      hold_pend     = 1'b0;
    end else begin
      check("matrix_done", matrix_done, prev_pop_last);
      if (hold_pend) begin
        check("hold_tvalid", AXIS_TVALID, 1);
        check("hold_tdata_tlast", {AXIS_TLAST, AXIS_TDATA}, held);
      end
      hold_pend     = AXIS_TVALID && !AXIS_TREADY;
      held          = {AXIS_TLAST, AXIS_TDATA};
      prev_pop_last = 1'b0;
      if (AXIS_TVALID && AXIS_TREADY) begin
        if (exp_q.size() == 0) begin
          check("unexpected_word", {AXIS_TLAST, AXIS_TDATA}, 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          mon_e = exp_q.pop_front();
          check("out_data", {16'd0, AXIS_TDATA}, {16'd0, mon_e[OUTW-1:0]});
          check("out_tlast", AXIS_TLAST, mon_e[OUTW]);
        end
        if (AXIS_TLAST) begin
          tlast_cnt++;
          last_tlast_data = AXIS_TDATA;
          prev_pop_last   = 1'b1;
        end
      end
    end
  end

  // Pushes elements from_idx..to_idx of an n-element matrix; K is only
  // meaningful on element 1, any other element drives a different K.
  task automatic push_words(input int k, input int n, input int from_idx,
                            input int to_idx, input int base);
    for (int idx = from_idx; idx <= to_idx; idx++) begin
      int waited = 0;
      bit rdy    = 1'b0;
      in_valid = 1'b1;
      in_data  = OUTW'(base + idx);
      K        = (idx == 1) ? KB'(k) : KB'((k == 4) ? 2 : 4);
      do begin
        @(negedge clk);
        rdy = in_ready;
        @(posedge clk);
        waited++;
      end while (!rdy && waited < 200);
      if (!rdy) begin
        check("push_timeout", 0, 1);
        in_valid = 1'b0;
        return;
      end
      exp_q.push_back({(idx == n), OUTW'(base + idx)});
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int cyc = 0;
    while (exp_q.size() != 0 && cyc < 3000) begin
      @(posedge clk);
      cyc++;
    end
    check(tag, exp_q.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  int t0;

  initial begin
    reset       = 1'b0;
    in_valid    = 1'b0;
    in_data     = '0;
    K           = KB'(3);
    AXIS_TREADY = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_tvalid", AXIS_TVALID, 0);
    check("rst_tlast", AXIS_TLAST, 0);
    check("rst_done", matrix_done, 0);
    check("rst_in_ready", in_ready, 1);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // K=3: 7*6 = 42 words
    t0 = tlast_cnt;
    push_words(3, 42, 1, 42, 0);
    drain("t1_drain");
    check("t1_tlast_count", tlast_cnt - t0, 1);
    check("t1_last_word", last_tlast_data, 42);

    // K=2 (8*7 = 56) then K=4 (6*5 = 30) back-to-back
    t0 = tlast_cnt;
    push_words(2, 56, 1, 56, 100);
    push_words(4, 30, 1, 30, 500);
    drain("t2_drain");
    check("t2_tlast_count", tlast_cnt - t0, 2);
    check("t2_last_word", last_tlast_data, 530);

    // Backpressure: FIFO fills after DEPTH pushes, head holds word 1
    t0 = tlast_cnt;
    AXIS_TREADY = 1'b0;
    push_words(3, 42, 1, 1, 0);
    @(negedge clk);
    check("t3_latency_tvalid", AXIS_TVALID, 1);
    check("t3_latency_tdata", AXIS_TDATA, 1);
    @(posedge clk);
    #1;
    push_words(3, 42, 2, 8, 0);
    @(negedge clk);
    check("t3_full_in_ready", in_ready, 0);
    check("t3_full_tdata", AXIS_TDATA, 1);
    repeat (3) @(negedge clk);
    check("t3_held_in_ready", in_ready, 0);
    check("t3_held_tvalid", AXIS_TVALID, 1);
    check("t3_held_tdata", AXIS_TDATA, 1);
    @(posedge clk);
    #1;
    fork
      push_words(3, 42, 9, 42, 0);
      begin
        repeat (5) @(posedge clk);
        #1;
        AXIS_TREADY = 1'b1;
      end
    join
    drain("t3_drain");
    check("t3_tlast_count", tlast_cnt - t0, 1);
    check("t3_last_word", last_tlast_data, 42);

    // TREADY toggling every cycle
    t0 = tlast_cnt;
    toggle_mode = 1'b1;
    push_words(3, 42, 1, 42, 1000);
    drain("t4_drain");
    toggle_mode = 1'b0;
    @(posedge clk);
    #1;
    AXIS_TREADY = 1'b1;
    check("t4_tlast_count", tlast_cnt - t0, 1);
    check("t4_last_word", last_tlast_data, 1042);

    // Reset mid-matrix discards buffered words
    push_words(3, 42, 1, 20, 2000);
    check("t5_tvalid_before", AXIS_TVALID, 1);
    reset = 1'b0;
    #1;
    check("t5_rst_tvalid", AXIS_TVALID, 0);
    check("t5_rst_tlast", AXIS_TLAST, 0);
    check("t5_rst_in_ready", in_ready, 1);
    exp_q.delete();
    repeat (2) @(posedge clk);
    check("t5_rst_done", matrix_done, 0);
    #1;
    reset = 1'b1;
    t0 = tlast_cnt;
    push_words(3, 42, 1, 42, 4000);
    drain("t5_drain");
    check("t5_tlast_count", tlast_cnt - t0, 1);
    check("t5_last_word", last_tlast_data, 4042);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
